// File: rtl/xfifo_sc_ext_if.sv
// Handshake bundle for xfifo_sc_ext: write side, read side, flush and the
// programmable thresholds, plus all status outputs.
//   master : producer/consumer side (drives din, wr_en, rd_en, flush, thresholds)
//   slave  : FIFO side (drives dout, flags, counters, per-cycle status)
interface xfifo_sc_ext_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  wr_ack;
  logic                  overflow;
  logic [ADDR_WIDTH:0]   prog_full_thresh;
  logic                  prog_full;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_en;
  logic                  empty;
  logic                  almost_empty;
  logic                  valid;
  logic                  underflow;
  logic [ADDR_WIDTH:0]   prog_empty_thresh;
  logic                  prog_empty;
  logic [ADDR_WIDTH:0]   data_count;

  modport master (
    output flush, din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
    input  full, almost_full, wr_ack, overflow, prog_full, dout, empty,
           almost_empty, valid, underflow, prog_empty, data_count
  );

  modport slave (
    input  flush, din, wr_en, rd_en, prog_full_thresh, prog_empty_thresh,
    output full, almost_full, wr_ack, overflow, prog_full, dout, empty,
           almost_empty, valid, underflow, prog_empty, data_count
  );
endinterface

// File: rtl/xfifo_sc_ext.sv
// Common-clock FIFO with standard or first-word-fall-through read mode,
// programmable prog_full/prog_empty thresholds, almost flags, data_count and
// a synchronous flush.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   f   : xfifo_sc_ext_if slave modport (write/read handshakes, flush,
//         thresholds, status flags, data_count)
module xfifo_sc_ext #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input logic           clk,
  input logic           rst,
  xfifo_sc_ext_if.slave f
);
  localparam int            DEPTH   = 1 << ADDR_WIDTH;
  localparam int            CW      = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]         wr_ptr, rd_ptr, data_count, next_count;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  full_q, almost_full_q, prog_full_q;
  logic                  empty_q, almost_empty_q, prog_empty_q;
  logic                  valid_q, wr_ack_q, overflow_q, underflow_q;
  logic                  wr_acc, rd_acc, ram_rd, head_valid_nxt;

  assign wr_acc = f.wr_en & ~full_q & ~f.flush;
  assign rd_acc = f.rd_en & ~empty_q & ~f.flush;

  // In FWFT mode the RAM feeds a head register whenever it is empty or being
  // popped; rd_ptr only counts words that have left the RAM, so the head
  // word's RAM slot is reusable while data_count still includes it.
  assign ram_rd = (FWFT != 0) ?
                  (~f.flush & (wr_ptr != rd_ptr) & (~valid_q | rd_acc)) :
                  rd_acc;
  assign head_valid_nxt = ram_rd | (valid_q & ~rd_acc);

  always_comb begin
    next_count = data_count;
    case ({wr_acc, rd_acc})
      2'b10:   next_count = data_count + ONE_C;
      2'b01:   next_count = data_count - ONE_C;
      default: next_count = data_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem[wr_ptr[ADDR_WIDTH-1:0]] <= f.din;
  end

  always_ff @(posedge clk) begin
    if (rst || f.flush) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      data_count     <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      prog_full_q    <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      prog_empty_q   <= 1'b1;
      valid_q        <= 1'b0;
      wr_ack_q       <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      // flush keeps the last read word on dout; only reset clears it
      if (rst) dout_q <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
      if (ram_rd) begin
        dout_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        rd_ptr <= rd_ptr + ONE_C;
      end
      data_count     <= next_count;
      full_q         <= (next_count == DEPTH_C);
      almost_full_q  <= (next_count >= DEPTH_C - ONE_C);
      prog_full_q    <= (next_count >= f.prog_full_thresh);
      almost_empty_q <= (next_count <= ONE_C);
      prog_empty_q   <= (next_count <= f.prog_empty_thresh);
      wr_ack_q       <= wr_acc;
      overflow_q     <= f.wr_en & full_q;
      underflow_q    <= f.rd_en & empty_q;
      if (FWFT != 0) begin
        valid_q <= head_valid_nxt;
        empty_q <= ~head_valid_nxt;
      end else begin
        valid_q <= rd_acc;
        empty_q <= (next_count == '0);
      end
    end
  end

  assign f.dout         = dout_q;
  assign f.valid        = valid_q;
  assign f.empty        = empty_q;
  assign f.almost_empty = almost_empty_q;
  assign f.prog_empty   = prog_empty_q;
  assign f.full         = full_q;
  assign f.almost_full  = almost_full_q;
  assign f.prog_full    = prog_full_q;
  assign f.wr_ack       = wr_ack_q;
  assign f.overflow     = overflow_q;
  assign f.underflow    = underflow_q;
  assign f.data_count   = data_count;
endmodule

// File: tb/tb_xfifo_sc_ext.sv
// Directed bench for xfifo_sc_ext: one standard-mode and one FWFT instance,
// both DEPTH=4, sharing clk/rst.
module tb_xfifo_sc_ext;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  xfifo_sc_ext_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) i0 ();
  xfifo_sc_ext_if #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) i1 ();

  xfifo_sc_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .f(i0)
  );
  xfifo_sc_ext #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .f(i1)
  );

  typedef struct {
    int wr; int rd; int din; int pft; int pet;
    int cnt; int emp; int ful; int af; int pf; int ae; int pe;
    int vld; int dout; int ack; int ovf; int unf;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl [NV];
  logic [7:0] q [$];
  logic [7:0] exp_d;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag, input logic [7:0] dout, input logic [2:0] cnt,
                         input logic emp, input logic ae, input logic pe, input logic ful,
                         input logic af, input logic pf, input logic ack, input logic ovf,
                         input logic vld, input logic unf);
    chk({tag, " dout"}, 32'(dout), 32'h0);
    chk({tag, " count"}, 32'(cnt), 32'h0);
    chk({tag, " empty"}, 32'(emp), 32'h1);
    chk({tag, " almost_empty"}, 32'(ae), 32'h1);
    chk({tag, " prog_empty"}, 32'(pe), 32'h1);
    chk({tag, " full"}, 32'(ful), 32'h0);
    chk({tag, " almost_full"}, 32'(af), 32'h0);
    chk({tag, " prog_full"}, 32'(pf), 32'h0);
    chk({tag, " wr_ack"}, 32'(ack), 32'h0);
    chk({tag, " overflow"}, 32'(ovf), 32'h0);
    chk({tag, " valid"}, 32'(vld), 32'h0);
    chk({tag, " underflow"}, 32'(unf), 32'h0);
  endtask

  initial begin
    //             wr rd din   pft pet cnt emp ful af pf ae pe vld dout  ack ovf unf
    tbl[0]  = '{1, 0, 'h11, 3, 1,  1, 0, 0, 0, 0, 1, 1, 0, 'h00, 1, 0, 0};
    tbl[1]  = '{1, 0, 'h22, 3, 1,  2, 0, 0, 0, 0, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[2]  = '{1, 0, 'h33, 3, 1,  3, 0, 0, 1, 1, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[3]  = '{1, 0, 'h44, 3, 1,  4, 0, 1, 1, 1, 0, 0, 0, 'h00, 1, 0, 0};
    tbl[4]  = '{1, 0, 'h55, 3, 1,  4, 0, 1, 1, 1, 0, 0, 0, 'h00, 0, 1, 0};
    tbl[5]  = '{0, 1, 'h00, 3, 1,  3, 0, 0, 1, 1, 0, 0, 1, 'h11, 0, 0, 0};
    tbl[6]  = '{0, 1, 'h00, 3, 1,  2, 0, 0, 0, 0, 0, 0, 1, 'h22, 0, 0, 0};
    tbl[7]  = '{0, 1, 'h00, 3, 1,  1, 0, 0, 0, 0, 1, 1, 1, 'h33, 0, 0, 0};
    tbl[8]  = '{0, 1, 'h00, 3, 1,  0, 1, 0, 0, 0, 1, 1, 1, 'h44, 0, 0, 0};
    tbl[9]  = '{0, 1, 'h00, 3, 1,  0, 1, 0, 0, 0, 1, 1, 0, 'h44, 0, 0, 1};
    tbl[10] = '{0, 0, 'h00, 3, 1,  0, 1, 0, 0, 0, 1, 1, 0, 'h44, 0, 0, 0};
    tbl[11] = '{1, 0, 'h66, 1, 1,  1, 0, 0, 0, 1, 1, 1, 0, 'h44, 1, 0, 0};
    tbl[12] = '{0, 0, 'h00, 5, 0,  1, 0, 0, 0, 0, 1, 0, 0, 'h44, 0, 0, 0};
    tbl[13] = '{0, 0, 'h00, 0, 4,  1, 0, 0, 0, 1, 1, 1, 0, 'h44, 0, 0, 0};
    tbl[14] = '{0, 1, 'h00, 3, 1,  0, 1, 0, 0, 0, 1, 1, 1, 'h66, 0, 0, 0};

    rst = 1'b1;
    i0.flush = 0; i0.wr_en = 0; i0.rd_en = 0; i0.din = '0;
    i0.prog_full_thresh = 3'd3; i0.prog_empty_thresh = 3'd1;
    i1.flush = 0; i1.wr_en = 0; i1.rd_en = 0; i1.din = '0;
    i1.prog_full_thresh = 3'd3; i1.prog_empty_thresh = 3'd1;
    step(); step();
    chk_rst("init std", i0.dout, i0.data_count, i0.empty, i0.almost_empty, i0.prog_empty,
            i0.full, i0.almost_full, i0.prog_full, i0.wr_ack, i0.overflow, i0.valid, i0.underflow);
    chk_rst("init fwft", i1.dout, i1.data_count, i1.empty, i1.almost_empty, i1.prog_empty,
            i1.full, i1.almost_full, i1.prog_full, i1.wr_ack, i1.overflow, i1.valid, i1.underflow);
    rst = 1'b0;

    // standard mode: fill, overflow, drain, underflow, threshold changes
    for (int k = 0; k < NV; k++) begin
      i0.wr_en = tbl[k].wr[0];
      i0.rd_en = tbl[k].rd[0];
      i0.din   = 8'(tbl[k].din);
      i0.prog_full_thresh  = 3'(tbl[k].pft);
      i0.prog_empty_thresh = 3'(tbl[k].pet);
      step();
      chk($sformatf("v%0d count", k), 32'(i0.data_count), tbl[k].cnt);
      chk($sformatf("v%0d empty", k), 32'(i0.empty), tbl[k].emp);
      chk($sformatf("v%0d full", k), 32'(i0.full), tbl[k].ful);
      chk($sformatf("v%0d almost_full", k), 32'(i0.almost_full), tbl[k].af);
      chk($sformatf("v%0d prog_full", k), 32'(i0.prog_full), tbl[k].pf);
      chk($sformatf("v%0d almost_empty", k), 32'(i0.almost_empty), tbl[k].ae);
      chk($sformatf("v%0d prog_empty", k), 32'(i0.prog_empty), tbl[k].pe);
      chk($sformatf("v%0d valid", k), 32'(i0.valid), tbl[k].vld);
      chk($sformatf("v%0d dout", k), 32'(i0.dout), tbl[k].dout);
      chk($sformatf("v%0d wr_ack", k), 32'(i0.wr_ack), tbl[k].ack);
      chk($sformatf("v%0d overflow", k), 32'(i0.overflow), tbl[k].ovf);
      chk($sformatf("v%0d underflow", k), 32'(i0.underflow), tbl[k].unf);
    end
    i0.wr_en = 0; i0.rd_en = 0;
    i0.prog_full_thresh = 3'd3; i0.prog_empty_thresh = 3'd1;

    // standard mode: 20 cycles of simultaneous read/write at count 2
    q.delete();
    for (int k = 0; k < 2; k++) begin
      i0.wr_en = 1; i0.din = 8'hA0 + 8'(k); q.push_back(i0.din);
      step();
    end
    for (int k = 0; k < 20; k++) begin
      i0.wr_en = 1; i0.rd_en = 1; i0.din = 8'hA2 + 8'(k);
      exp_d = q.pop_front();
      q.push_back(i0.din);
      step();
      chk($sformatf("std sim%0d count", k), 32'(i0.data_count), 32'd2);
      chk($sformatf("std sim%0d valid", k), 32'(i0.valid), 32'd1);
      chk($sformatf("std sim%0d dout", k), 32'(i0.dout), 32'(exp_d));
    end
    i0.wr_en = 0;
    for (int k = 0; k < 2; k++) begin
      i0.rd_en = 1;
      exp_d = q.pop_front();
      step();
      chk($sformatf("std drain%0d dout", k), 32'(i0.dout), 32'(exp_d));
    end
    i0.rd_en = 0;
    chk("std drain empty", 32'(i0.empty), 32'd1);

    // FWFT: 20 cycles of simultaneous read/write at count 2
    q.delete();
    for (int k = 0; k < 2; k++) begin
      i1.wr_en = 1; i1.din = 8'hB0 + 8'(k); q.push_back(i1.din);
      step();
    end
    i1.wr_en = 0;
    chk("fwft pre count", 32'(i1.data_count), 32'd2);
    chk("fwft pre dout", 32'(i1.dout), 32'hB0);
    for (int k = 0; k < 20; k++) begin
      i1.wr_en = 1; i1.rd_en = 1; i1.din = 8'hB2 + 8'(k);
      void'(q.pop_front());
      q.push_back(i1.din);
      step();
      chk($sformatf("fwft sim%0d count", k), 32'(i1.data_count), 32'd2);
      chk($sformatf("fwft sim%0d valid", k), 32'(i1.valid), 32'd1);
      chk($sformatf("fwft sim%0d dout", k), 32'(i1.dout), 32'(q[0]));
    end
    i1.wr_en = 0;
    void'(q.pop_front());
    step();
    chk("fwft drain dout", 32'(i1.dout), 32'(q[0]));
    step();
    i1.rd_en = 0;
    chk("fwft drain empty", 32'(i1.empty), 32'd1);
    chk("fwft drain count", 32'(i1.data_count), 32'd0);

    // FWFT: write to empty shows data two edges later
    i1.wr_en = 1; i1.din = 8'hA5;
    step();
    i1.wr_en = 0;
    chk("fwft a5 empty t", 32'(i1.empty), 32'd1);
    chk("fwft a5 count t", 32'(i1.data_count), 32'd1);
    step();
    chk("fwft a5 empty t1", 32'(i1.empty), 32'd0);
    chk("fwft a5 dout", 32'(i1.dout), 32'hA5);
    i1.rd_en = 1;
    step();
    i1.rd_en = 0;
    chk("fwft a5 popped", 32'(i1.empty), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      i1.wr_en = 1; i1.din = 8'(k);
      step();
    end
    i1.wr_en = 0;
    chk("fwft 3w dout", 32'(i1.dout), 32'h01);
    chk("fwft 3w count", 32'(i1.data_count), 32'd3);
    i1.rd_en = 1;
    step();
    chk("fwft pop1 dout", 32'(i1.dout), 32'h02);
    step();
    chk("fwft pop2 dout", 32'(i1.dout), 32'h03);
    step();
    chk("fwft pop3 empty", 32'(i1.empty), 32'd1);
    chk("fwft pop3 underflow", 32'(i1.underflow), 32'd0);
    step();
    chk("fwft underflow", 32'(i1.underflow), 32'd1);
    chk("fwft underflow count", 32'(i1.data_count), 32'd0);
    i1.rd_en = 0;

    // standard mode: mid-stream flush at count 3 with a write pending
    for (int k = 0; k < 4; k++) begin
      i0.wr_en = 1; i0.din = 8'hC1 + 8'(k);
      step();
    end
    i0.wr_en = 0; i0.rd_en = 1;
    step();
    i0.rd_en = 0;
    chk("flush pre dout", 32'(i0.dout), 32'hC1);
    chk("flush pre count", 32'(i0.data_count), 32'd3);
    i0.flush = 1; i0.wr_en = 1; i0.din = 8'hEE;
    step();
    i0.flush = 0; i0.wr_en = 0;
    chk("flush count", 32'(i0.data_count), 32'd0);
    chk("flush empty", 32'(i0.empty), 32'd1);
    chk("flush wr_ack", 32'(i0.wr_ack), 32'd0);
    chk("flush valid", 32'(i0.valid), 32'd0);
    chk("flush dout held", 32'(i0.dout), 32'hC1);
    i0.wr_en = 1; i0.din = 8'hD1;
    step();
    i0.wr_en = 0; i0.rd_en = 1;
    step();
    i0.rd_en = 0;
    chk("post flush dout", 32'(i0.dout), 32'hD1);
    chk("post flush count", 32'(i0.data_count), 32'd0);

    // reset at count 4 on both instances, then resume
    for (int k = 0; k < 4; k++) begin
      i0.wr_en = 1; i0.din = 8'h90 + 8'(k);
      i1.wr_en = 1; i1.din = 8'h90 + 8'(k);
      step();
    end
    i0.wr_en = 0; i1.wr_en = 0;
    chk("pre rst std full", 32'(i0.full), 32'd1);
    chk("pre rst fwft count", 32'(i1.data_count), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_rst("rst std", i0.dout, i0.data_count, i0.empty, i0.almost_empty, i0.prog_empty,
            i0.full, i0.almost_full, i0.prog_full, i0.wr_ack, i0.overflow, i0.valid, i0.underflow);
    chk_rst("rst fwft", i1.dout, i1.data_count, i1.empty, i1.almost_empty, i1.prog_empty,
            i1.full, i1.almost_full, i1.prog_full, i1.wr_ack, i1.overflow, i1.valid, i1.underflow);
    i0.wr_en = 1; i0.din = 8'h77;
    i1.wr_en = 1; i1.din = 8'h77;
    step();
    i0.wr_en = 0; i1.wr_en = 0; i0.rd_en = 1;
    step();
    i0.rd_en = 0;
    chk("resume std dout", 32'(i0.dout), 32'h77);
    chk("resume std valid", 32'(i0.valid), 32'd1);
    chk("resume fwft dout", 32'(i1.dout), 32'h77);
    chk("resume fwft valid", 32'(i1.valid), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
